// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: sequencer state encoding and page geometry.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam int OFF_W = 12;
  localparam int PPN_W = 32 - OFF_W;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry output register from the second fetch stage to decode.
module fetch_out_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  input  logic        load_tlbr,
  input  logic        consume,
  input  logic        clear,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  output logic        excp_tlbr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= '0;
      pc         <= '0;
      inst_valid <= 1'b0;
      excp_tlbr  <= 1'b0;
    end else if (clear) begin
      inst_valid <= 1'b0;
    end else if (load) begin
      inst       <= load_inst;
      pc         <= load_pc;
      inst_valid <= 1'b1;
      excp_tlbr  <= load_tlbr;
    end else if (consume) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch2 sequencer: ICache request, response wait, orphan drop and
// handoff to decode through a one-entry output register.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  input  logic              pc_valid,
  input  logic              clear,
  input  logic              tlb_hit,
  input  logic [19:0]       tlb_ppn,
  output logic [31:0]       p_addr,
  output logic              p_addr_valid,
  input  logic              cache_ready,
  input  logic [31:0]       cache_read,
  input  logic              out_ready,
  output logic [31:0]       inst,
  output logic [31:0]       pc,
  output logic              inst_valid,
  output logic              excp_tlbr,
  output logic              stall_fetch,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  fetch_state_e state, state_n;
  logic [31:0]  addr_q;
  logic [31:0]  pc_q;
  logic         busy;
  logic         accept;
  logic         hit_acc;
  logic         miss_acc;
  logic         rsp_load;

  assign busy        = (state == S_WAIT) || (state == S_DROP);
  assign stall_fetch = busy || (state == S_HOLD && !out_ready);
  assign accept      = pc_valid && !stall_fetch && !clear;
  assign hit_acc     = accept && tlb_hit;
  assign miss_acc    = accept && !tlb_hit;
  assign rsp_load    = (state == S_WAIT) && cache_ready && !clear;

  // Accept cycle bypasses the latch so the request leaves the same cycle.
  assign p_addr       = hit_acc ? {tlb_ppn, pc_in[OFF_W-1:0]} : addr_q;
  assign p_addr_valid = hit_acc || busy;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_HOLD: begin
        if (clear)                            state_n = S_IDLE;
        else if (hit_acc)                     state_n = S_WAIT;
        else if (miss_acc)                    state_n = S_HOLD;
        else if (state == S_HOLD && !out_ready) state_n = S_HOLD;
        else                                  state_n = S_IDLE;
      end
      S_WAIT: begin
        if (cache_ready) state_n = clear ? S_IDLE : S_HOLD;
        else if (clear)  state_n = S_DROP;
      end
      S_DROP: begin
        if (cache_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
      pc_q   <= '0;
    end else begin
      state <= state_n;
      if (hit_acc) begin
        addr_q <= {tlb_ppn, pc_in[OFF_W-1:0]};
        pc_q   <= pc_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if (busy && !(&perf_stall_cnt))
      perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
  end

  fetch_out_buf u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (miss_acc || rsp_load),
    .load_inst  (miss_acc ? 32'd0 : cache_read),
    .load_pc    (miss_acc ? pc_in : pc_q),
    .load_tlbr  (miss_acc),
    .consume    (state == S_HOLD && out_ready),
    .clear      (clear),
    .inst       (inst),
    .pc         (pc),
    .inst_valid (inst_valid),
    .excp_tlbr  (excp_tlbr)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch sequencer.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        clear;
  logic        tlb_hit;
  logic [19:0] tlb_ppn;
  logic [31:0] p_addr;
  logic        p_addr_valid;
  logic        cache_ready;
  logic [31:0] cache_read;
  logic        out_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        excp_tlbr;
  logic        stall_fetch;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int failures = 0;

  // Model: is a cache request outstanding, is its answer unwanted,
  // and what instruction (if any) is parked for decode.
  bit          m_busy;
  bit          m_drop;
  bit          m_hv;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  bit          m_tlbr;
  logic [31:0] m_lpc;
  logic [31:0] m_addr;
  longint      m_cnt;
  int          m_lat;

  always #5 clk = ~clk;

  fetch_ctrl #(.PERF_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .clear          (clear),
    .tlb_hit        (tlb_hit),
    .tlb_ppn        (tlb_ppn),
    .p_addr         (p_addr),
    .p_addr_valid   (p_addr_valid),
    .cache_ready    (cache_ready),
    .cache_read     (cache_read),
    .out_ready      (out_ready),
    .inst           (inst),
    .pc             (pc),
    .inst_valid     (inst_valid),
    .excp_tlbr      (excp_tlbr),
    .stall_fetch    (stall_fetch),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_hv = 0;
    m_inst = '0; m_pc = '0; m_tlbr = 0;
    m_lpc = '0; m_addr = '0; m_cnt = 0; m_lat = 0;
  endtask

  task automatic cycle(input logic pv, input logic [31:0] pci,
                       input logic hit, input logic [19:0] ppn,
                       input logic clr, input logic ordy,
                       input logic crdy, input logic [31:0] cdat);
    bit          stall_e;
    bit          acc;
    bit          pav_e;
    logic [31:0] pa_e;
    @(negedge clk);
    pc_valid = pv; pc_in = pci; tlb_hit = hit; tlb_ppn = ppn;
    clear = clr; out_ready = ordy;
    cache_ready = crdy; cache_read = cdat;
    #1;
    stall_e = m_busy || (m_hv && !ordy);
    acc     = pv && !stall_e && !clr;
    pav_e   = m_busy || (acc && hit);
    pa_e    = (acc && hit) ? {ppn, pci[11:0]} : m_addr;
    chk("stall_fetch", stall_fetch, stall_e);
    chk("p_addr_valid", p_addr_valid, pav_e);
    if (pav_e) chk("p_addr", p_addr, pa_e);
    chk("inst_valid", inst_valid, m_hv);
    if (m_hv) begin
      chk("inst", inst, m_inst);
      chk("pc", pc, m_pc);
      chk("excp_tlbr", excp_tlbr, m_tlbr);
    end
    chk("perf", perf_stall_cnt, m_cnt);
    if (m_busy) begin
      if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
      if (crdy) begin
        if (!m_drop && !clr) begin
          m_hv = 1; m_inst = cdat; m_pc = m_lpc; m_tlbr = 0;
        end
        m_busy = 0; m_drop = 0;
      end else begin
        if (clr) m_drop = 1;
        if (m_lat > 0) m_lat--;
      end
    end else if (clr) begin
      m_hv = 0;
    end else if (acc && hit) begin
      m_busy = 1; m_drop = 0; m_hv = 0;
      m_lpc = pci; m_addr = pa_e;
      m_lat = $urandom_range(0, 3);
    end else if (acc) begin
      m_hv = 1; m_inst = '0; m_pc = pci; m_tlbr = 1;
    end else if (ordy) begin
      m_hv = 0;
    end
    @(posedge clk);
  endtask

  task automatic idle_cycle(input logic crdy);
    cycle(0, 32'd0, 1, 20'd0, 0, 1, crdy, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pc_in = '0; pc_valid = 0; clear = 0; tlb_hit = 0; tlb_ppn = '0;
    cache_ready = 0; cache_read = '0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_pav", p_addr_valid, 0);
    chk("rst_stall", stall_fetch, 0);
    chk("rst_perf", perf_stall_cnt, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", pc, 0);
    @(negedge clk);
    rst = 1'b0;

    // Hit with a 3-cycle cache.
    cycle(1, 32'h1C00_0000, 1, 20'h1C000, 0, 1, 0, 0);
    idle_cycle(0);
    idle_cycle(0);
    cycle(0, 32'd0, 1, 20'd0, 0, 0, 1, 32'h0280_0C0C);
    #1;
    chk("hit_inst", inst, 32'h0280_0C0C);
    chk("hit_pc", pc, 32'h1C00_0000);
    chk("hit_valid", inst_valid, 1);
    chk("hit_perf", perf_stall_cnt, 3);

    // Backpressure for 5 cycles, then accept on the first out_ready.
    repeat (5) cycle(1, 32'h1C00_0004, 1, 20'h1C000, 0, 0, 0, 0);
    cycle(1, 32'h1C00_0004, 1, 20'h1C000, 0, 1, 0, 0);
    idle_cycle(1);
    idle_cycle(0);

    // TLB miss.
    do_reset();
    cycle(1, 32'h0040_0010, 0, 20'h12345, 0, 0, 0, 0);
    #1;
    chk("miss_valid", inst_valid, 1);
    chk("miss_tlbr", excp_tlbr, 1);
    chk("miss_inst", inst, 0);
    idle_cycle(0);

    // Clear in WAIT, response in cycle 4, new PC in cycle 5.
    do_reset();
    cycle(1, 32'h1C00_0100, 1, 20'h1C000, 0, 1, 0, 0);
    cycle(0, 32'd0, 1, 20'd0, 1, 1, 0, 0);
    idle_cycle(0);
    idle_cycle(0);
    cycle(1, 32'h1C00_0200, 1, 20'h1C000, 0, 1, 1, 32'hDEAD_BEEF);
    cycle(1, 32'h1C00_0200, 1, 20'h1C000, 0, 1, 0, 0);
    chk("clr_p_addr_valid", p_addr_valid, 1);
    idle_cycle(1);
    idle_cycle(0);

    // Simultaneous clear and cache_ready in WAIT.
    cycle(1, 32'h1C00_0300, 1, 20'h1C000, 0, 1, 0, 0);
    cycle(0, 32'd0, 1, 20'd0, 1, 1, 1, 32'h1111_2222);
    #1;
    chk("clrrdy_valid", inst_valid, 0);
    chk("clrrdy_stall", stall_fetch, 0);
    idle_cycle(0);

    // Asynchronous reset pulse mid-WAIT.
    cycle(1, 32'h1C00_0400, 1, 20'h1C000, 0, 1, 0, 0);
    idle_cycle(0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pav", p_addr_valid, 0);
    chk("arst_stall", stall_fetch, 0);
    chk("arst_perf", perf_stall_cnt, 0);
    chk("arst_valid", inst_valid, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic crdy;
      logic [31:0] a;
      a = $urandom;
      if (m_busy) crdy = (m_lat == 0);
      else        crdy = ($urandom_range(0, 15) == 0);
      cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 7) != 0,
            20'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, crdy, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
